// File: rtl/sync_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_event_fifo                                                            |
// | Rising-edge event capture behind a CDC synchronizer, buffered in a small   |
// | FIFO with valid/ready output, fill level and overflow/drop accounting.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         sync_data,
    input  logic                     sync_valid,
    input  logic                     clr_overflow,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    logic                   r_valid_q;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic                   r_overflow;
    logic [CNT_W-1:0]       r_drop_cnt;

    logic                   w_edge;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_cnt_sat;

    assign w_edge    = sync_valid && !r_valid_q;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) &&
                       (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_pop     = !w_empty && m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push    = w_edge && (!w_full || w_pop);
    assign w_drop    = w_edge && w_full && !w_pop;
    assign w_cnt_sat = &r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_valid_q <= sync_valid;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= sync_data;
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_overflow) begin
                r_drop_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (!w_cnt_sat) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    // Gating with the empty flag keeps m_data at zero out of reset without
    // needing reset on the storage array.
    assign m_valid    = !w_empty;
    assign m_data     = w_empty ? '0 : r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign level      = r_wr_ptr - r_rd_ptr;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sync_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sync_event_fifo                                                         |
// | Scoreboard bench: expected words queued on each accepted event.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sync_event_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sync_data;
    logic             sync_valid;
    logic             clr_overflow;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [2:0]       level;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] sb_q [$];
    logic             mdl_vq;
    logic             mdl_ovf;
    int               mdl_cnt;

    sync_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_data    (sync_data),
        .sync_valid   (sync_valid),
        .clr_overflow (clr_overflow),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Compare DUT state after the previous edge, then advance the model to
    // reflect the inputs that the coming posedge will sample.
    always @(negedge clk) begin
        logic do_pop, is_full, ev, drop;
        if (!rst_n) begin
            sb_q.delete();
            mdl_vq  = 1'b0;
            mdl_ovf = 1'b0;
            mdl_cnt = 0;
        end else begin
            chk("level", {29'd0, level}, sb_q.size());
            chk("m_valid", {31'd0, m_valid}, {31'd0, sb_q.size() != 0});
            if (sb_q.size() != 0) begin
                chk("m_data", {24'd0, m_data}, {24'd0, sb_q[0]});
            end
            chk("overflow", {31'd0, overflow}, {31'd0, mdl_ovf});
            chk("drop_count", {24'd0, drop_count}, mdl_cnt);

            do_pop  = (sb_q.size() != 0) && m_ready;
            is_full = (sb_q.size() == DEPTH);
            ev      = sync_valid && !mdl_vq;
            drop    = ev && is_full && !do_pop;
            if (do_pop) void'(sb_q.pop_front());
            if (ev && !drop) sb_q.push_back(sync_data);
            if (drop) begin
                mdl_ovf = 1'b1;
                if (clr_overflow) mdl_cnt = 1;
                else if (mdl_cnt < 255) mdl_cnt++;
            end else if (clr_overflow) begin
                mdl_ovf = 1'b0;
                mdl_cnt = 0;
            end
            mdl_vq = sync_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int hold);
        sync_data  = d;
        sync_valid = 1'b1;
        tick(hold);
        sync_valid = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] fill_words [4];
        fill_words[0] = 8'h11; fill_words[1] = 8'h22;
        fill_words[2] = 8'h33; fill_words[3] = 8'h44;

        rst_n = 1'b0; sync_data = '0; sync_valid = 1'b0;
        clr_overflow = 1'b0; m_ready = 1'b0;
        tick(2);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_level", {29'd0, level}, 0);
        chk("rst_m_data", {24'd0, m_data}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_drop_count", {24'd0, drop_count}, 0);
        rst_n = 1'b1;
        tick(2);

        // Single event held high for several cycles
        m_ready = 1'b1;
        send(8'hA5, 4);
        tick(2);

        // Fill then drain
        m_ready = 1'b0;
        foreach (fill_words[i]) send(fill_words[i], 1);
        tick(1);
        chk("fill_level", {29'd0, level}, 4);
        chk("fill_head", {24'd0, m_data}, 8'h11);
        m_ready = 1'b1;
        tick(5);
        m_ready = 1'b0;

        // Overflow while full, drain, clear
        foreach (fill_words[i]) send(fill_words[i], 1);
        send(8'h55, 1); send(8'h66, 1); send(8'h77, 1);
        chk("ovf_count", {24'd0, drop_count}, 3);
        m_ready = 1'b1;
        tick(5);
        m_ready = 1'b0;
        clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0; tick(1);

        // Full with edge and pop together
        foreach (fill_words[i]) send(fill_words[i], 1);
        sync_data = 8'h88; sync_valid = 1'b1; m_ready = 1'b1;
        tick(1);
        sync_valid = 1'b0; m_ready = 1'b0;
        tick(1);
        chk("full_pop_level", {29'd0, level}, 4);
        m_ready = 1'b1;
        tick(5);

        // Back-to-back across pointer wrap
        for (int i = 0; i < 10; i++) send(8'hC0 + i[7:0], 1);
        tick(2);

        // Saturate the drop counter, including a drop coinciding with a clear
        m_ready = 1'b0;
        foreach (fill_words[i]) send(fill_words[i], 1);
        send(8'hE0, 1);
        sync_data = 8'hE1; sync_valid = 1'b1; clr_overflow = 1'b1;
        tick(1);
        sync_valid = 1'b0; clr_overflow = 1'b0;
        tick(1);
        chk("drop_beats_clr", {24'd0, drop_count}, 1);
        for (int i = 0; i < 256; i++) send(i[7:0], 1);
        chk("drop_saturated", {24'd0, drop_count}, 8'hFF);

        // Mid-operation asynchronous reset with level 3 and overflow set
        m_ready = 1'b1;
        tick(5);
        m_ready = 1'b0;
        send(8'h31, 1); send(8'h32, 1); send(8'h33, 1);
        chk("pre_rst_level", {29'd0, level}, 3);
        rst_n = 1'b0;
        #1;
        chk("async_m_valid", {31'd0, m_valid}, 0);
        chk("async_level", {29'd0, level}, 0);
        chk("async_overflow", {31'd0, overflow}, 0);
        chk("async_drop_count", {24'd0, drop_count}, 0);
        sync_data = 8'h9C; sync_valid = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_level", {29'd0, level}, 1);
        chk("post_rst_data", {24'd0, m_data}, 8'h9C);
        tick(3);
        sync_valid = 1'b0;
        m_ready = 1'b1;
        tick(4);
        chk("final_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
